// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM for the multicycle 32-bit processor.
// Sequences fetch / decode / execute / memory / writeback, drives ALUOp and
// all datapath enables and mux selects, stalls on mem_ready and pulses
// instr_done in the final cycle of every instruction.
//
// Optional feature macro: ILLEGAL_OP_TRAP_EN
//   defined   - unknown opcodes park the FSM in TRAP and raise illegal_op
//   undefined - unknown opcodes retire as a NOP straight from DECODE
module multicycle_control #(
    parameter int MAX_WAIT = 15,
    parameter int STATE_W  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               Branch,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic [1:0]         PCSrc,
    output logic               instr_done,
    output logic               mem_timeout,
    output logic [STATE_W-1:0] state
`ifdef ILLEGAL_OP_TRAP_EN
    ,
    output logic               illegal_op
`endif
);

    // Fixed state encoding; the debug port exposes these values directly.
    typedef enum logic [STATE_W-1:0] {
        S_FETCH   = STATE_W'(0),
        S_DECODE  = STATE_W'(1),
        S_MEMADR  = STATE_W'(2),
        S_MEMRD   = STATE_W'(3),
        S_MEMWB   = STATE_W'(4),
        S_MEMWR   = STATE_W'(5),
        S_EXECUTE = STATE_W'(6),
        S_ALUWB   = STATE_W'(7),
        S_BRANCH  = STATE_W'(8),
        S_ADDIEX  = STATE_W'(9),
        S_ADDIWB  = STATE_W'(10),
        S_JUMP    = STATE_W'(11),
        S_TRAP    = STATE_W'(12)
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [7:0] MAX_W8 = 8'(MAX_WAIT);

    state_t     state_q, state_d;
    logic [7:0] wait_cnt, wait_nxt;
    logic       waiting;

    assign state = state_q;

`ifdef ILLEGAL_OP_TRAP_EN
    // Held for as long as the FSM is parked; reset leaves TRAP on its edge.
    assign illegal_op = (state_q == S_TRAP);
`endif

    // State register; reset returns to FETCH on the same edge, even mid-instruction.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Next-state and Moore output decode; FETCH and MEMWR also gate on mem_ready.
    always_comb begin
        state_d    = S_FETCH;
        PCWrite    = 1'b0;
        Branch     = 1'b0;
        IorD       = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        MemtoReg   = 1'b0;
        RegDst     = 1'b0;
        RegWrite   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b00;
        PCSrc      = 2'b00;
        instr_done = 1'b0;

        case (state_q)
            S_FETCH: begin
                IorD    = 1'b0;
                MemRead = 1'b1;
                ALUSrcA = 1'b0;
                ALUSrcB = 2'b01;
                ALUOp   = 2'b00;
                PCSrc   = 2'b00;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                state_d = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                // Branch target is precomputed here so BRANCH can compare in one cycle.
                ALUSrcA = 1'b0;
                ALUSrcB = 2'b11;
                ALUOp   = 2'b00;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
`ifdef ILLEGAL_OP_TRAP_EN
                        state_d = S_TRAP;
`else
                        state_d    = S_FETCH;
                        instr_done = 1'b1;
`endif
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = 2'b00;
                // Opcode is re-read here; a corrupted IR abandons the access.
                case (opcode)
                    OP_LW:   state_d = S_MEMRD;
                    OP_SW:   state_d = S_MEMWR;
                    default: begin
`ifdef ILLEGAL_OP_TRAP_EN
                        state_d = S_TRAP;
`else
                        state_d = S_FETCH;
`endif
                    end
                endcase
            end
            S_MEMRD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
                state_d = mem_ready ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                RegDst     = 1'b0;
                MemtoReg   = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWR: begin
                IorD       = 1'b1;
                MemWrite   = 1'b1;
                instr_done = mem_ready;
                state_d    = mem_ready ? S_FETCH : S_MEMWR;
            end
            S_EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b00;
                ALUOp   = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegDst     = 1'b1;
                MemtoReg   = 1'b0;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b00;
                ALUOp      = 2'b01;
                PCSrc      = 2'b01;
                Branch     = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = 2'b00;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegDst     = 1'b0;
                MemtoReg   = 1'b0;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                PCSrc      = 2'b10;
                PCWrite    = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
`ifdef ILLEGAL_OP_TRAP_EN
            S_TRAP: begin
                // Everything quiet; only reset gets the FSM out.
                state_d = S_TRAP;
            end
`endif
            default: begin
                // Unused encodings recover to FETCH with every output low.
                state_d = S_FETCH;
            end
        endcase

        // Reset suppresses every side-effecting enable in the cycle it is seen.
        if (reset) begin
            state_d    = S_FETCH;
            PCWrite    = 1'b0;
            Branch     = 1'b0;
            MemRead    = 1'b0;
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            RegWrite   = 1'b0;
            instr_done = 1'b0;
        end
    end

    // Memory stall detection: only the three memory-waiting states count.
    always_comb begin
        waiting = ((state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR))
                  && !mem_ready;
        if (!waiting || (state_d != state_q)) wait_nxt = 8'd0;
        else if (wait_cnt >= MAX_W8)          wait_nxt = MAX_W8;
        else                                  wait_nxt = wait_cnt + 8'd1;
    end

    // Saturating stall counter and sticky timeout flag; timeout never alters sequencing.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt    <= 8'd0;
            mem_timeout <= 1'b0;
        end else begin
            wait_cnt <= wait_nxt;
            if (wait_nxt == MAX_W8) mem_timeout <= 1'b1;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed self-checking bench for multicycle_control.
// Each task drives one scenario and compares against hand-derived values.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSrc;
    logic       instr_done, mem_timeout;
    logic [3:0] state;
`ifdef ILLEGAL_OP_TRAP_EN
    logic       illegal_op;
`endif

    int total = 0;
    int bad   = 0;

    multicycle_control #(.MAX_WAIT(15), .STATE_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .PCWrite    (PCWrite),
        .Branch     (Branch),
        .IorD       (IorD),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .MemtoReg   (MemtoReg),
        .RegDst     (RegDst),
        .RegWrite   (RegWrite),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUOp      (ALUOp),
        .PCSrc      (PCSrc),
        .instr_done (instr_done),
        .mem_timeout(mem_timeout),
        .state      (state)
`ifdef ILLEGAL_OP_TRAP_EN
        ,
        .illegal_op (illegal_op)
`endif
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are examined 2 time units after the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_ready = 1'b1; opcode = 6'b000000;
        tick(); tick();
        #1;
        total++; if (state !== 4'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", state); end
        total++; if (mem_timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout: got %b want 0", mem_timeout); end
        total++; if (MemRead !== 1'b0) begin bad++; $display("FAIL reset_memread: got %b want 0", MemRead); end
        total++; if ({PCWrite, IRWrite, instr_done} !== 3'b000) begin bad++; $display("FAIL reset_enables: got %b want 000", {PCWrite, IRWrite, instr_done}); end
    endtask

    task automatic test_rtype();
        logic [3:0] exp_st [5] = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0};
        logic       exp_dn [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        reset = 1'b0; mem_ready = 1'b1; opcode = 6'b000000;
        #1;
        for (int i = 0; i < 5; i++) begin
            total++; if (state !== exp_st[i]) begin bad++; $display("FAIL rtype_state[%0d]: got %0d want %0d", i, state, exp_st[i]); end
            total++; if (instr_done !== exp_dn[i]) begin bad++; $display("FAIL rtype_done[%0d]: got %b want %b", i, instr_done, exp_dn[i]); end
            if (i == 0) begin
                total++; if ({IRWrite, PCWrite, ALUSrcB} !== 4'b1101) begin bad++; $display("FAIL rtype_fetch: got %b want 1101", {IRWrite, PCWrite, ALUSrcB}); end
            end
            if (i == 2) begin
                total++; if (ALUOp !== 2'b10) begin bad++; $display("FAIL rtype_aluop: got %b want 10", ALUOp); end
            end
            if (i == 3) begin
                total++; if ({RegWrite, RegDst, MemtoReg} !== 3'b110) begin bad++; $display("FAIL rtype_wb: got %b want 110", {RegWrite, RegDst, MemtoReg}); end
            end
            if (i < 4) tick();
        end
    endtask

    task automatic test_lw();
        logic [3:0] exp_st [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        opcode = 6'b100011; mem_ready = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            total++; if (state !== exp_st[i]) begin bad++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, state, exp_st[i]); end
            if (i == 4) begin
                total++; if ({RegWrite, MemtoReg, RegDst, instr_done} !== 4'b1101) begin bad++; $display("FAIL lw_memwb: got %b want 1101", {RegWrite, MemtoReg, RegDst, instr_done}); end
            end
            if (i < 5) tick();
        end
        // Stalled load: FETCH, DECODE, MEMADR, 4x MEMRD, MEMWB = 8 cycles.
        tick(); tick();
        #1;
        total++; if (state !== 4'd2) begin bad++; $display("FAIL lwst_memadr: got %0d want 2", state); end
        tick();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_ready = 1'b1;
            #1;
            total++; if (state !== 4'd3) begin bad++; $display("FAIL lwst_hold[%0d]: got %0d want 3", i, state); end
            total++; if ({MemRead, IorD} !== 2'b11) begin bad++; $display("FAIL lwst_rd[%0d]: got %b want 11", i, {MemRead, IorD}); end
            tick();
        end
        #1;
        total++; if ({state, instr_done} !== {4'd4, 1'b1}) begin bad++; $display("FAIL lwst_wb: got %0d/%b want 4/1", state, instr_done); end
        tick();
    endtask

    task automatic test_sw_beq();
        opcode = 6'b101011; mem_ready = 1'b1;
        tick(); tick();
        #1;
        total++; if ({state, MemWrite} !== {4'd2, 1'b0}) begin bad++; $display("FAIL sw_memadr: got %0d/%b want 2/0", state, MemWrite); end
        tick();
        mem_ready = 1'b0;
        #1;
        total++; if ({state, MemWrite, IorD, instr_done} !== {4'd5, 3'b110}) begin bad++; $display("FAIL sw_stall: got %0d/%b want 5/110", state, {MemWrite, IorD, instr_done}); end
        tick();
        mem_ready = 1'b1;
        #1;
        total++; if ({state, MemWrite, instr_done} !== {4'd5, 2'b11}) begin bad++; $display("FAIL sw_done: got %0d/%b want 5/11", state, {MemWrite, instr_done}); end
        tick();
        #1;
        total++; if ({state, MemWrite} !== {4'd0, 1'b0}) begin bad++; $display("FAIL sw_back: got %0d/%b want 0/0", state, MemWrite); end
        opcode = 6'b000100;
        tick(); tick();
        #1;
        total++; if (state !== 4'd8) begin bad++; $display("FAIL beq_state: got %0d want 8", state); end
        total++; if ({ALUOp, Branch, PCSrc, instr_done, ALUSrcA} !== 7'b0110111) begin bad++; $display("FAIL beq_outs: got %b want 0110111", {ALUOp, Branch, PCSrc, instr_done, ALUSrcA}); end
        tick();
        #1;
        total++; if (state !== 4'd0) begin bad++; $display("FAIL beq_back: got %0d want 0", state); end
    endtask

    task automatic test_jump_addi();
        opcode = 6'b000010; mem_ready = 1'b1;
        tick(); tick();
        #1;
        total++; if (state !== 4'd11) begin bad++; $display("FAIL j_state: got %0d want 11", state); end
        total++; if ({PCWrite, PCSrc, instr_done} !== 4'b1101) begin bad++; $display("FAIL j_outs: got %b want 1101", {PCWrite, PCSrc, instr_done}); end
        tick();
        opcode = 6'b001000;
        tick(); tick();
        #1;
        total++; if ({state, ALUSrcB, ALUSrcA} !== {4'd9, 3'b101}) begin bad++; $display("FAIL addi_ex: got %0d/%b want 9/101", state, {ALUSrcB, ALUSrcA}); end
        tick();
        #1;
        total++; if ({state, RegWrite, RegDst, MemtoReg, instr_done} !== {4'd10, 4'b1001}) begin bad++; $display("FAIL addi_wb: got %0d/%b want 10/1001", state, {RegWrite, RegDst, MemtoReg, instr_done}); end
        tick();
    endtask

    task automatic test_timeout();
        opcode = 6'b000000; mem_ready = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        #1;
        total++; if ({state, mem_timeout} !== {4'd0, 1'b0}) begin bad++; $display("FAIL to_before: got %0d/%b want 0/0", state, mem_timeout); end
        tick();
        #1;
        total++; if (mem_timeout !== 1'b1) begin bad++; $display("FAIL to_rise: got %b want 1", mem_timeout); end
        tick(); tick(); tick();
        #1;
        total++; if ({state, mem_timeout, MemRead} !== {4'd0, 2'b11}) begin bad++; $display("FAIL to_sticky: got %0d/%b want 0/11", state, {mem_timeout, MemRead}); end
        mem_ready = 1'b1;
        tick();
        #1;
        total++; if ({state, mem_timeout} !== {4'd1, 1'b1}) begin bad++; $display("FAIL to_proceed: got %0d/%b want 1/1", state, mem_timeout); end
        reset = 1'b1;
        tick();
        #1;
        total++; if ({state, mem_timeout} !== {4'd0, 1'b0}) begin bad++; $display("FAIL to_clear: got %0d/%b want 0/0", state, mem_timeout); end
        reset = 1'b0;
    endtask

    task automatic test_illegal();
        opcode = 6'b111111; mem_ready = 1'b1;
        tick();
        #1;
        total++; if (state !== 4'd1) begin bad++; $display("FAIL ill_decode: got %0d want 1", state); end
`ifdef ILLEGAL_OP_TRAP_EN
        total++; if (instr_done !== 1'b0) begin bad++; $display("FAIL ill_done: got %b want 0", instr_done); end
        tick(); tick(); tick();
        #1;
        total++; if ({state, illegal_op, MemRead, PCWrite} !== {4'd12, 3'b100}) begin bad++; $display("FAIL ill_trap: got %0d/%b want 12/100", state, {illegal_op, MemRead, PCWrite}); end
        reset = 1'b1;
        tick();
        #1;
        total++; if ({state, illegal_op} !== {4'd0, 1'b0}) begin bad++; $display("FAIL ill_reset: got %0d/%b want 0/0", state, illegal_op); end
        reset = 1'b0;
`else
        total++; if (instr_done !== 1'b1) begin bad++; $display("FAIL ill_done: got %b want 1", instr_done); end
        tick();
        #1;
        total++; if (state !== 4'd0) begin bad++; $display("FAIL ill_nop: got %0d want 0", state); end
`endif
    endtask

    task automatic test_reset_midinstr();
        opcode = 6'b100011; mem_ready = 1'b1;
        #1;
        total++; if (state !== 4'd0) begin bad++; $display("FAIL rst_mid_start: got %0d want 0", state); end
        tick(); tick();
        #1;
        total++; if (state !== 4'd2) begin bad++; $display("FAIL rst_mid_memadr: got %0d want 2", state); end
        reset = 1'b1;
        #1;
        total++; if ({MemRead, MemWrite, RegWrite} !== 3'b000) begin bad++; $display("FAIL rst_mid_en: got %b want 000", {MemRead, MemWrite, RegWrite}); end
        tick();
        #1;
        total++; if ({state, MemRead, MemWrite} !== {4'd0, 2'b00}) begin bad++; $display("FAIL rst_mid_after: got %0d/%b want 0/00", state, {MemRead, MemWrite}); end
        reset = 1'b0;
        #1;
        total++; if ({state, MemRead, IorD} !== {4'd0, 2'b10}) begin bad++; $display("FAIL rst_mid_refetch: got %0d/%b want 0/10", state, {MemRead, IorD}); end
    endtask

    initial begin
        reset = 1'b1; mem_ready = 1'b0; opcode = 6'b000000;
        test_reset();
        test_rtype();
        test_lw();
        test_sw_beq();
        test_jump_addi();
        test_timeout();
        test_illegal();
        test_reset_midinstr();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Main control FSM for the multicycle 32-bit processor. It sequences fetch, decode, execute, memory and writeback for each instruction. It drives ALUOp to the ALU control decoder and all datapath enables and mux selects. It stalls on a memory ready handshake and reports instruction completion.

Parameters:
MAX_WAIT, 15, maximum consecutive stall cycles in a memory state before mem_timeout is set (1..255)
STATE_W, 4, state register width; fixed encoding FETCH=0 DECODE=1 MEMADR=2 MEMRD=3 MEMWB=4 MEMWR=5 EXECUTE=6 ALUWB=7 BRANCH=8 ADDIEX=9 ADDIWB=10 JUMP=11 TRAP=12

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
opcode  input  6  instr[31:26] from instruction register
mem_ready  input  1  memory completes the current access this cycle
PCWrite  output  1  unconditional PC load
Branch  output  1  PC load if ALU zero
IorD  output  1  0 = PC addresses memory, 1 = ALUOut
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
IRWrite  output  1  instruction register load
MemtoReg  output  1  register write data: 1 = MDR, 0 = ALUOut
RegDst  output  1  write register: 1 = rd, 0 = rt
RegWrite  output  1  register file write enable
ALUSrcA  output  1  0 = PC, 1 = reg A
ALUSrcB  output  2  00 = reg B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
ALUOp  output  2  00 = add, 01 = sub, 10 = decode funct; 11 is never driven
PCSrc  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
instr_done  output  1  one-cycle pulse in the final cycle of each instruction
mem_timeout  output  1  sticky stall-timeout flag
state  output  STATE_W  current state, for debug

Behaviour:
Moore FSM. Outputs decode from the state register only, except the mem_ready gating listed below. Any output not listed for a state is 0.
While reset is high, next state = FETCH, the wait counter is cleared, mem_timeout is cleared, and every enable (PCWrite, Branch, MemRead, MemWrite, IRWrite, RegWrite, instr_done) is forced to 0. Reset takes effect mid-instruction on the same edge.
FETCH: IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00. IRWrite and PCWrite equal mem_ready. Stays in FETCH until mem_ready=1, then goes to DECODE.
DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by opcode:
  100011 (lw) or 101011 (sw) -> MEMADR
  000000 (R-type) -> EXECUTE
  000100 (beq) -> BRANCH
  001000 (addi) -> ADDIEX
  000010 (j) -> JUMP
  any other opcode -> see Optional Feature
MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEMRD for lw, MEMWR for sw; opcode is sampled again here and must still be valid.
MEMRD: IorD=1, MemRead=1. Holds until mem_ready, then goes to MEMWB.
MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, instr_done=1. Goes to FETCH.
MEMWR: IorD=1, MemWrite=1, instr_done=mem_ready. Holds until mem_ready, then goes to FETCH.
EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Goes to ALUWB.
ALUWB: RegDst=1, MemtoReg=0, RegWrite=1, instr_done=1. Goes to FETCH.
BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1, instr_done=1. Goes to FETCH.
ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to ADDIWB.
ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1, instr_done=1. Goes to FETCH.
JUMP: PCSrc=10, PCWrite=1, instr_done=1. Goes to FETCH.
Latency with mem_ready held high: R-type 4 cycles, lw 5, sw 4, beq 3, j 3, addi 4.
Wait counter: 8-bit. Increments each cycle in FETCH, MEMRD or MEMWR while mem_ready=0. Clears on mem_ready=1 or on any state change. When the count reaches MAX_WAIT, mem_timeout sets and stays set until reset. The counter saturates at MAX_WAIT. The FSM keeps waiting after a timeout; the timeout never causes a state change.
Unused state encodings go to FETCH on the next edge with all enables 0.

Optional Feature:
Macro ILLEGAL_OP_TRAP_EN.
Defined: an unknown opcode in DECODE goes to TRAP. TRAP drives all outputs 0 and asserts the extra output illegal_op=1. The FSM stays in TRAP until reset, which clears illegal_op.
Undefined: an unknown opcode is treated as a NOP. DECODE goes to FETCH with instr_done=1 in the DECODE cycle. The illegal_op port does not exist.

Test Plan:
1. reset=1 for 2 cycles, release, mem_ready=1, opcode=000000 -> states 0,1,6,7,0; ALUOp=10 in EXECUTE; RegWrite=1 and RegDst=1 in ALUWB; instr_done pulses once at cycle 4.
2. opcode=100011 with mem_ready=1 -> states 0,1,2,3,4. Then repeat with mem_ready=0 for 3 cycles in MEMRD -> MEMRD held for 4 cycles, MemRead=1 and IorD=1 throughout, total 8 cycles.
3. opcode=101011 -> MemWrite=1 only in MEMWR; instr_done coincides with mem_ready. Then opcode=000100 -> BRANCH with ALUOp=01, Branch=1, PCSrc=01.
4. opcode=000010, then opcode=001000 -> JUMP asserts PCWrite=1 and PCSrc=10 in its 3rd cycle; addi produces ALUSrcB=10 in ADDIEX and RegWrite=1 with RegDst=0 in ADDIWB.
5. mem_ready=0 held in FETCH, MAX_WAIT=15 -> mem_timeout rises when the count reaches 15 and stays set. Release mem_ready -> FSM proceeds to DECODE with mem_timeout still 1. Assert reset -> mem_timeout=0.
6. opcode=111111 -> with ILLEGAL_OP_TRAP_EN: state=12 and illegal_op=1 until reset. Without it: state returns to 0 after DECODE and instr_done=1. Separately, assert reset during MEMADR -> state=0 on the next edge and no MemRead or MemWrite is issued.
